// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load-store unit types: buffered store entry and word offset
package lsu_pkg;

  localparam int LSU_XLEN    = 32;
  localparam int WORD_OFFSET = 2;

  // addr must stay the first member: hazard logic slices it from the MSBs
  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] data;
    logic [3:0]          sel;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-to-core store (c2c_w) and load (c2c_r) channels
interface c2c_w #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] data;
  logic [3:0]      sel;
  logic            we;
  logic            ack;

  modport master (output addr, data, sel, we, input ack);
  modport slave  (input addr, data, sel, we, output ack);
endinterface

interface c2c_r #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [3:0]      sel;
  logic            re;
  logic [XLEN-1:0] data;
  logic            ack;

  modport master (output addr, sel, re, input data, ack);
  modport slave  (input addr, sel, re, output data, ack);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two FIFO with all-entries view and per-slot valid mask
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PW:0]                 count_q;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Payload is deliberately unreset; validity comes only from the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr} < count_q) valid[i] = 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];
  assign entries   = mem;
  assign count     = count_q;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load word-address hazard blocking
module store_buffer
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  c2c_w.slave  lsu_w,
  c2c_r.slave  lsu_r,
  c2c_w.master mem_w,
  c2c_r.master mem_r,
  output logic empty
);

  localparam int WIDTH = $bits(sb_entry_t);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WA_W  = LSU_XLEN - WORD_OFFSET;

  sb_entry_t                   wr_entry;
  sb_entry_t                   head;
  logic [WIDTH-1:0]            head_bits;
  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            slot_hit;
  logic [DEPTH-1:0]            unused_slot_bits;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        fifo_empty;
  logic                        ack_q;
  logic                        push;
  logic                        pop;
  logic                        hazard;

  assign wr_entry = '{addr: LSU_XLEN'(lsu_w.addr),
                      data: LSU_XLEN'(lsu_w.data),
                      sel:  lsu_w.sel};

  // ack_q blocks the cycle after an accept so a held we is not taken twice;
  // a full buffer refuses even when the head is leaving this cycle.
  assign push = lsu_w.we & ~full & ~ack_q;
  assign pop  = ~fifo_empty & mem_w.ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_q <= 1'b0;
    else          ack_q <= push;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head_data (head_bits),
    .full      (full),
    .empty     (fifo_empty),
    .count     (count),
    .entries   (entries),
    .valid     (valid)
  );

  assign head = sb_entry_t'(head_bits);

  assign lsu_w.ack  = ack_q;
  assign mem_w.we   = ~fifo_empty;
  assign mem_w.addr = XLEN'(head.addr);
  assign mem_w.data = XLEN'(head.data);
  assign mem_w.sel  = head.sel;

  // Byte enables are ignored: any overlap at word granularity holds the load.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_hit[g] = valid[g] &&
                         (entries[g][WIDTH-1 -: WA_W] == WA_W'(lsu_r.addr[XLEN-1:WORD_OFFSET]));
    assign unused_slot_bits[g] = ^entries[g][WIDTH-WA_W-1:0];
  end

  assign hazard = |slot_hit;

  assign mem_r.re   = lsu_r.re & ~hazard;
  assign mem_r.addr = lsu_r.addr;
  assign mem_r.sel  = lsu_r.sel;
  assign lsu_r.data = mem_r.data;
  assign lsu_r.ack  = mem_r.ack & ~hazard;

  assign empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized scoreboard bench for store_buffer
module tb_store_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } exp_t;

  logic clk;
  logic reset_n;
  logic empty;

  c2c_w #(.XLEN(XLEN)) lsu_w ();
  c2c_r #(.XLEN(XLEN)) lsu_r ();
  c2c_w #(.XLEN(XLEN)) mem_w ();
  c2c_r #(.XLEN(XLEN)) mem_r ();

  store_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lsu_w   (lsu_w),
    .lsu_r   (lsu_r),
    .mem_w   (mem_w),
    .mem_r   (mem_r),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   drained  = 0;
  exp_t model_q[$];
  exp_t sb_q[$];
  bit   ack_pend = 1'b0;
  bit   last_ack;
  bit   last_re;
  bit   last_rack;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_hazard(logic [31:0] a);
    foreach (model_q[i]) begin
      if ((model_q[i].addr >> 2) == (a >> 2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: check outputs at the falling edge, then apply the buffering rules.
  task automatic cycle();
    bit   hz;
    bit   push;
    bit   pop;
    exp_t e;
    @(negedge clk);
    hz        = model_hazard(lsu_r.addr);
    last_ack  = lsu_w.ack;
    last_re   = mem_r.re;
    last_rack = lsu_r.ack;
    chk("lsu_w_ack", lsu_w.ack, ack_pend);
    chk("empty", empty, model_q.size() == 0);
    chk("mem_w_we", mem_w.we, model_q.size() != 0);
    chk("mem_r_re", mem_r.re, lsu_r.re & ~hz);
    chk("lsu_r_ack", lsu_r.ack, mem_r.ack & ~hz);
    chk("lsu_r_data", lsu_r.data, mem_r.data);
    chk("mem_r_addr", mem_r.addr, lsu_r.addr);
    chk("mem_r_sel", mem_r.sel, lsu_r.sel);
    push = lsu_w.we && (model_q.size() < DEPTH) && !ack_pend;
    pop  = (model_q.size() != 0) && mem_w.ack;
    e    = '{addr: lsu_w.addr, data: lsu_w.data, sel: lsu_w.sel};
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (push) begin
      model_q.push_back(e);
      sb_q.push_back(e);
    end
    ack_pend = push;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    lsu_w.we   = 1'b1;
    lsu_w.addr = a;
    lsu_w.data = d;
    lsu_w.sel  = s;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("store_ack_seen", got, 1'b1);
    lsu_w.we = 1'b0;
  endtask

  task automatic drain();
    lsu_w.we  = 1'b0;
    mem_w.ack = 1'b1;
    for (int i = 0; i < 40 && model_q.size() != 0; i++) cycle();
    mem_w.ack = 1'b0;
    cycle();
    chk("drain_empty", empty, 1'b1);
  endtask

  // Scoreboard: every write handshake on mem_w must match the oldest accepted store.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && mem_w.we === 1'b1 && mem_w.ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_write: got addr 0x%0h data 0x%0h with nothing expected", mem_w.addr, mem_w.data);
        end else begin
          e = sb_q.pop_front();
          chk("drain_addr", mem_w.addr, e.addr);
          chk("drain_data", mem_w.data, e.data);
          chk("drain_sel", mem_w.sel, e.sel);
          drained++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset_n    = 1'b0;
    lsu_w.we   = 1'b0;
    lsu_w.addr = '0;
    lsu_w.data = '0;
    lsu_w.sel  = '0;
    lsu_r.re   = 1'b0;
    lsu_r.addr = '0;
    lsu_r.sel  = '0;
    mem_w.ack  = 1'b0;
    mem_r.ack  = 1'b0;
    mem_r.data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", empty, 1'b1);
    chk("reset_mem_we", mem_w.we, 1'b0);
    chk("reset_ack", lsu_w.ack, 1'b0);
    chk("reset_count", dut.count, 0);
    reset_n = 1'b1;

    // single store
    store(32'h100, 32'hDEADBEEF, 4'hF);
    drain();

    // fill: four accepted, fifth stalls until one drain, count stays full
    for (int i = 0; i < 4; i++) store(32'h1000 + i * 4, 32'hF000 + i, 4'h3);
    lsu_w.we   = 1'b1;
    lsu_w.addr = 32'h1010;
    lsu_w.data = 32'hF004;
    lsu_w.sel  = 4'hC;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_stall_ack", last_ack, 1'b0);
    end
    mem_w.ack = 1'b1;
    cycle();
    chk("full_pop_no_ack", last_ack, 1'b0);
    mem_w.ack = 1'b0;
    cycle();
    chk("full_push_cycle_ack", last_ack, 1'b0);
    cycle();
    chk("fifth_acked", last_ack, 1'b1);
    lsu_w.we = 1'b0;
    chk("full_count", dut.count, DEPTH);
    drain();

    // load hazard on a buffered word; an unrelated word passes meanwhile
    store(32'h104, $urandom, 4'h1);
    lsu_r.re   = 1'b1;
    lsu_r.sel  = 4'h4;
    lsu_r.addr = 32'h106;
    mem_r.ack  = 1'b1;
    mem_r.data = $urandom;
    cycle();
    chk("hazard_block_re", last_re, 1'b0);
    chk("hazard_block_ack", last_rack, 1'b0);
    lsu_r.addr = 32'h200;
    cycle();
    chk("nohazard_pass_re", last_re, 1'b1);
    lsu_r.addr = 32'h106;
    mem_w.ack  = 1'b1;
    cycle();
    chk("hazard_still_block", last_re, 1'b0);
    mem_w.ack = 1'b0;
    cycle();
    chk("hazard_release_re", last_re, 1'b1);
    chk("hazard_release_ack", last_rack, 1'b1);
    lsu_r.re  = 1'b0;
    mem_r.ack = 1'b0;

    // wrap: ten stores with the memory acking every cycle
    d0 = drained;
    mem_w.ack = 1'b1;
    for (int i = 0; i < 10; i++) store(32'h2000 + ($urandom_range(0, 63) << 2), i, 4'($urandom));
    drain();
    chk("wrap_drained", drained - d0, 10);
    chk("wrap_sb_empty", sb_q.size(), 0);

    // held we: two cycles past the ack yields exactly one more entry
    lsu_w.we   = 1'b1;
    lsu_w.addr = 32'h300;
    lsu_w.data = 32'hA5A5A5A5;
    lsu_w.sel  = 4'hF;
    cycle();  chk("held_ack0", last_ack, 1'b0);
    cycle();  chk("held_ack1", last_ack, 1'b1);
    cycle();  chk("held_ack2", last_ack, 1'b0);
    lsu_w.we = 1'b0;
    cycle();  chk("held_ack3", last_ack, 1'b1);
    cycle();  chk("held_ack4", last_ack, 1'b0);
    chk("held_count", dut.count, 2);
    drain();

    // reset mid-drain: three buffered entries are abandoned
    for (int i = 0; i < 3; i++) store(32'h400 + i * 4, 32'h77 + i, 4'hF);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_we", mem_w.we, 1'b0);
    chk("rst_mid_empty", empty, 1'b1);
    chk("rst_mid_ack", lsu_w.ack, 1'b0);
    model_q.delete();
    sb_q.delete();
    ack_pend = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    mem_w.ack = 1'b1;
    repeat (5) cycle();
    mem_w.ack = 1'b0;

    // random traffic with a narrow address window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      lsu_w.we   = 1'($urandom_range(0, 1));
      lsu_w.addr = 32'h100 + ($urandom_range(0, 15) << 1);
      lsu_w.data = $urandom;
      lsu_w.sel  = 4'($urandom);
      mem_w.ack  = ($urandom_range(0, 2) == 0);
      lsu_r.re   = 1'($urandom_range(0, 1));
      lsu_r.addr = 32'h100 + ($urandom_range(0, 15) << 1);
      lsu_r.sel  = 4'($urandom);
      mem_r.ack  = 1'($urandom_range(0, 1));
      mem_r.data = $urandom;
      cycle();
    end
    lsu_r.re  = 1'b0;
    mem_r.ack = 1'b0;
    drain();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port lsu_w  c2c_w.slave  iface  store requests from load-store unit (addr, data, sel[3:0], we, ack).
REQ-006 SHALL have port lsu_r  c2c_r.slave  iface  load requests from load-store unit (addr, sel[3:0], re, data, ack).
REQ-007 SHALL have port mem_w  c2c_w.master  iface  store drain to data memory.
REQ-008 SHALL have port mem_r  c2c_r.master  iface  load path to data memory.
REQ-009 SHALL have port empty  output  1  high when no entry is buffered; used for fence/drain.

Function
REQ-010 SHALL hold up to DEPTH entries {addr, data, sel} in FIFO order with wr_ptr, rd_ptr and count ($clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
REQ-011 SHALL enqueue lsu_w {addr, data, sel} on a cycle when lsu_w.we=1, count<DEPTH and ack_q=0.
REQ-012 SHALL drive lsu_w.ack from a register ack_q, set for exactly one cycle after an enqueue, else 0; store latency is 1 cycle when not full.
REQ-013 SHALL, when full, leave ack_q=0 and not enqueue; the master holds we and is accepted in the first cycle count<DEPTH.
REQ-014 SHALL not treat a same-cycle pop as making room: full blocks enqueue regardless of mem_w.ack.
REQ-015 SHALL drive mem_w.we=1 whenever count>0, with mem_w.addr/data/sel from the head entry, held stable until mem_w.ack.
REQ-016 SHALL pop the head on a cycle when mem_w.we=1 and mem_w.ack=1; simultaneous push and pop leave count unchanged and advance both pointers.
REQ-017 SHALL compute hazard=1 when any valid entry's word address (addr[XLEN-1:2]) equals lsu_r.addr[XLEN-1:2], sel ignored.
REQ-018 SHALL drive mem_r.re = lsu_r.re & ~hazard; mem_r.addr and mem_r.sel pass lsu_r values through combinationally.
REQ-019 SHALL drive lsu_r.data = mem_r.data and lsu_r.ack = mem_r.ack & ~hazard; a hazarded load waits until matching entries drain.
REQ-020 SHALL not forward buffered data to loads; ordering is only via REQ-017..019.
REQ-021 SHALL drive empty = (count==0) combinationally.
REQ-022 SHALL treat lsu_w.we deasserted in the ack cycle as normal; no second enqueue, because ack_q=1 blocks it.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear wr_ptr, rd_ptr, count and ack_q; mem_w.we=0, lsu_w.ack=0, empty=1.
REQ-024 SHALL discard all buffered entries on reset mid-drain; an in-flight mem_w request is abandoned.
REQ-025 SHALL keep entry storage registers unreset; only the valid/count state is reset.

Structure
REQ-026 SHALL take the entry typedef (addr, data, sel) and the word-address offset constant (2) from the shared package lsu_pkg.
REQ-027 SHALL implement storage as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, plus all-entries read for the hazard compare).
REQ-028 SHALL keep hazard compare, ack register and bus mapping in store_buffer.

Verification
REQ-029 SHALL cover single store: we, addr=0x100, data=0xDEADBEEF, sel=0xF -> lsu_w.ack one cycle later; mem_w presents the same values; empty=1 after mem_w.ack.
REQ-030 SHALL cover fill: 5 stores with mem_w.ack held 0 -> 4 acked, 5th stalled; one mem_w.ack -> 5th acked next cycle, count stays 4.
REQ-031 SHALL cover a load hazard: store to 0x104 buffered, load 0x106 -> mem_r.re=0 until drain, then load issued; load 0x200 meanwhile passes immediately.
REQ-032 SHALL cover wrap: 10 stores with mem_w.ack every cycle -> drained in order, data 0..9, no loss or duplication.
REQ-033 SHALL cover reset mid-drain: 3 buffered, reset_n pulsed low -> mem_w.we=0 and empty=1 immediately; no stale write after release.
REQ-034 SHALL cover held we: master holds we for 2 cycles after ack -> exactly one additional entry, acked separately.
